// File: rtl/btn_step_if.sv
// Button/strobe bundle between the raw button pins and the step conditioner.
//
// Signals:
//   BTN0, BTN1        raw asynchronous button levels, 1 = pressed
//   STEP_UP, STEP_DN  single-cycle step strobes toward the up/down counter
//   BTN0_DB, BTN1_DB  debounced button levels
//
// Modports:
//   master : the side that owns the buttons and consumes strobes / debounced levels
//   slave  : the conditioner, which samples the buttons and produces everything else
interface btn_step_if;
  logic BTN0;
  logic BTN1;
  logic STEP_UP;
  logic STEP_DN;
  logic BTN0_DB;
  logic BTN1_DB;

  modport master (
    output BTN0, BTN1,
    input  STEP_UP, STEP_DN, BTN0_DB, BTN1_DB
  );

  modport slave (
    input  BTN0, BTN1,
    output STEP_UP, STEP_DN, BTN0_DB, BTN1_DB
  );
endinterface

// File: rtl/btn_step_conditioner.sv
// Button front end for the LED up/down counter.
//
// Synchronises and debounces BTN0/BTN1, arbitrates direction (BTN0 wins) and
// emits single-cycle STEP_UP/STEP_DN strobes: one as soon as a debounced press
// is seen, then one every REPEAT_CYCLES while the button stays held.
//
// Ports:
//   CLOCK        in   system clock, all logic on posedge
//   RESET        in   synchronous, active-low reset
//   bus          slave modport of btn_step_if (BTN0/BTN1 in; STEP_UP, STEP_DN,
//                BTN0_DB, BTN1_DB out)
//   fsm_state_o  out  direction FSM state (0 = IDLE, 1 = UP, 2 = DN)
//
// Strobe semantics: STEP_UP/STEP_DN are clock enables, each high for exactly
// one CLOCK cycle per step and never high together. There is no back-pressure;
// the consumer must act on every cycle a strobe is high.
module btn_step_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 1_250_000,
  parameter int REPEAT_CYCLES = 125_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  btn_step_if.slave  bus,
  output logic [1:0] fsm_state_o
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2
  } state_t;

  // Synchronisers: bit 0 takes the raw pin, the top bit is the usable level.
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic                   btn0_s, btn1_s;

  logic             btn0_db_q, btn0_db_d, btn1_db_q, btn1_db_d;
  logic [DEB_W-1:0] deb0_cnt_q, deb0_cnt_d, deb1_cnt_q, deb1_cnt_d;

  state_t           state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             step_up_q, step_up_d, step_dn_q, step_dn_d;

  assign btn0_s = sync0_q[SYNC_STAGES-1];
  assign btn1_s = sync1_q[SYNC_STAGES-1];

  // Debounce: count consecutive cycles where the synchronised level differs
  // from the debounced one; any agreeing cycle restarts the count. The flip
  // happens on the DEB_CYCLES-th differing cycle, so the counter never needs
  // to hold DEB_CYCLES itself.
  always_comb begin
    btn0_db_d  = btn0_db_q;
    deb0_cnt_d = '0;
    if (btn0_s != btn0_db_q) begin
      if (deb0_cnt_q == DEB_LAST) begin
        btn0_db_d = btn0_s;
      end else begin
        deb0_cnt_d = deb0_cnt_q + DEB_W'(1);
      end
    end
  end

  always_comb begin
    btn1_db_d  = btn1_db_q;
    deb1_cnt_d = '0;
    if (btn1_s != btn1_db_q) begin
      if (deb1_cnt_q == DEB_LAST) begin
        btn1_db_d = btn1_s;
      end else begin
        deb1_cnt_d = deb1_cnt_q + DEB_W'(1);
      end
    end
  end

  // Direction FSM. rep_q counts held cycles since the last strobe; it is
  // cleared whenever a strobe fires or the direction changes, so it stops at
  // REPEAT_CYCLES-1 and cannot wrap.
  always_comb begin
    state_d   = state_q;
    rep_d     = '0;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn0_db_q) begin
          state_d   = ST_UP;
          step_up_d = 1'b1;
        end else if (btn1_db_q) begin
          state_d   = ST_DN;
          step_dn_d = 1'b1;
        end
      end
      ST_UP: begin
        if (!btn0_db_q) begin
          if (btn1_db_q) begin
            state_d   = ST_DN;
            step_dn_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (rep_q == REP_LAST) begin
          step_up_d = 1'b1;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
      ST_DN: begin
        // BTN0 has priority and preempts a running down-repeat.
        if (btn0_db_q) begin
          state_d   = ST_UP;
          step_up_d = 1'b1;
        end else if (!btn1_db_q) begin
          state_d = ST_IDLE;
        end else if (rep_q == REP_LAST) begin
          step_dn_d = 1'b1;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      sync0_q    <= '0;
      sync1_q    <= '0;
      btn0_db_q  <= 1'b0;
      btn1_db_q  <= 1'b0;
      deb0_cnt_q <= '0;
      deb1_cnt_q <= '0;
      state_q    <= ST_IDLE;
      rep_q      <= '0;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
    end else begin
      sync0_q    <= {sync0_q[SYNC_STAGES-2:0], bus.BTN0};
      sync1_q    <= {sync1_q[SYNC_STAGES-2:0], bus.BTN1};
      btn0_db_q  <= btn0_db_d;
      btn1_db_q  <= btn1_db_d;
      deb0_cnt_q <= deb0_cnt_d;
      deb1_cnt_q <= deb1_cnt_d;
      state_q    <= state_d;
      rep_q      <= rep_d;
      step_up_q  <= step_up_d;
      step_dn_q  <= step_dn_d;
    end
  end

  assign bus.STEP_UP = step_up_q;
  assign bus.STEP_DN = step_dn_q;
  assign bus.BTN0_DB = btn0_db_q;
  assign bus.BTN1_DB = btn1_db_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Testbench for btn_step_conditioner with SYNC_STAGES=2, DEB_CYCLES=4,
// REPEAT_CYCLES=10. "Cycle k" of a sequence is the value seen after the k-th
// posedge counted from the first edge that samples the sequence's stimulus.
module tb_btn_step_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int REP  = 10;

  typedef int iq_t[$];

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic b0, b1;
  logic [1:0] fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  btn_step_if ifc ();
  assign ifc.BTN0 = b0;
  assign ifc.BTN1 = b1;

  btn_step_conditioner #(
    .SYNC_STAGES  (SYNC),
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .CLOCK      (clk),
    .RESET      (rst_n),
    .bus        (ifc.slave),
    .fsm_state_o(fsm_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_list(input string name, input iq_t got, input iq_t exp);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  // ---------------- behavioural model ----------------
  // Pins reach the debouncer through a SYNC-deep delay line. A debounced level
  // flips once the last DEB synchronised samples all disagree with it. While a
  // direction is held, strobes fire whenever the number of cycles since
  // entering that direction is a multiple of REP.
  int m_dl0[SYNC], m_dl1[SYNC];
  int m_w0[DEB], m_w1[DEB];
  int m_db0, m_db1;
  int m_mode;   // 0 idle, 1 up, 2 down
  int m_age;
  int m_su, m_sd;

  always @(posedge clk) begin
    int s0, s1, su, sd, diff0, diff1;
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) begin m_dl0[i] = 0; m_dl1[i] = 0; end
      for (int i = 0; i < DEB; i++) begin m_w0[i] = 0; m_w1[i] = 0; end
      m_db0 = 0; m_db1 = 0; m_mode = 0; m_age = 0; m_su = 0; m_sd = 0;
    end else begin
      s0 = m_dl0[SYNC-1];
      s1 = m_dl1[SYNC-1];
      su = 0;
      sd = 0;
      case (m_mode)
        0: begin
          if (m_db0 != 0) begin m_mode = 1; m_age = 0; su = 1; end
          else if (m_db1 != 0) begin m_mode = 2; m_age = 0; sd = 1; end
        end
        1: begin
          if (m_db0 == 0) begin
            if (m_db1 != 0) begin m_mode = 2; m_age = 0; sd = 1; end
            else m_mode = 0;
          end else begin
            m_age++;
            if (m_age % REP == 0) su = 1;
          end
        end
        default: begin
          if (m_db0 != 0) begin m_mode = 1; m_age = 0; su = 1; end
          else if (m_db1 == 0) m_mode = 0;
          else begin
            m_age++;
            if (m_age % REP == 0) sd = 1;
          end
        end
      endcase
      m_su = su;
      m_sd = sd;
      for (int i = DEB - 1; i > 0; i--) begin m_w0[i] = m_w0[i-1]; m_w1[i] = m_w1[i-1]; end
      m_w0[0] = s0;
      m_w1[0] = s1;
      diff0 = 1;
      diff1 = 1;
      for (int i = 0; i < DEB; i++) begin
        if (m_w0[i] == m_db0) diff0 = 0;
        if (m_w1[i] == m_db1) diff1 = 0;
      end
      if (diff0 != 0) m_db0 = 1 - m_db0;
      if (diff1 != 0) m_db1 = 1 - m_db1;
      for (int i = SYNC - 1; i > 0; i--) begin m_dl0[i] = m_dl0[i-1]; m_dl1[i] = m_dl1[i-1]; end
      m_dl0[0] = int'(b0);
      m_dl1[0] = int'(b1);
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_step_up", int'(ifc.STEP_UP), m_su);
      check("m_step_dn", int'(ifc.STEP_DN), m_sd);
      check("m_btn0_db", int'(ifc.BTN0_DB), m_db0);
      check("m_btn1_db", int'(ifc.BTN1_DB), m_db1);
      check("never_both", int'(ifc.STEP_UP & ifc.STEP_DN), 0);
    end
  end

  // ---------------- driver tasks ----------------
  int up_q[$], dn_q[$], db0_hi[$], db1_hi[$];
  int exp_q[$];

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b0; b0 = 1'b0; b1 = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive pins for edge k of a sequence; record what is seen as cycle k.
  task automatic run_seq(input int kind, input int ncyc);
    up_q.delete(); dn_q.delete(); db0_hi.delete(); db1_hi.delete();
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (ifc.STEP_UP) up_q.push_back(k);
        if (ifc.STEP_DN) dn_q.push_back(k);
        if (ifc.BTN0_DB) db0_hi.push_back(k);
        if (ifc.BTN1_DB) db1_hi.push_back(k);
      end
      rst_n = 1'b1;
      b0 = 1'b0;
      b1 = 1'b0;
      case (kind)
        2: b0 = (k <= 34);
        3: b1 = (k < 20) ? (((k / 2) % 2) == 0) : 1'b1;
        4: begin b0 = (k < 30); b1 = 1'b1; end
        5: begin b0 = 1'b1; rst_n = !(k == 12 || k == 13); end
        6: b0 = (k < 3);
        default: ;
      endcase
    end
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    rst_n = 1'b0;
    b0 = 1'b1;
    b1 = 1'b1;

    // 1: reset held with both buttons pressed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_en = 1'b1;
      check("rst_step_up", int'(ifc.STEP_UP), 0);
      check("rst_step_dn", int'(ifc.STEP_DN), 0);
      check("rst_btn0_db", int'(ifc.BTN0_DB), 0);
      check("rst_btn1_db", int'(ifc.BTN1_DB), 0);
      check("rst_fsm_idle", int'(fsm_state), 0);
    end

    // 2: BTN0 held cycles 0..34
    do_reset();
    run_seq(2, 50);
    exp_q = '{7, 17, 27, 37};
    check_list("t2_up", up_q, exp_q);
    check("t2_dn_count", dn_q.size(), 0);
    check("t2_db0_count", db0_hi.size(), 35);
    if (db0_hi.size() > 0) begin
      check("t2_db0_first", db0_hi[0], 6);
      check("t2_db0_last", db0_hi[db0_hi.size()-1], 40);
    end

    // 3: BTN1 bounces for 20 cycles, then held (last edge at cycle 20)
    do_reset();
    run_seq(3, 35);
    check("t3_db1_count", db1_hi.size(), 10);
    if (db1_hi.size() > 0) check("t3_db1_first", db1_hi[0], 26);
    exp_q = '{27};
    check_list("t3_dn", dn_q, exp_q);
    check("t3_up_count", up_q.size(), 0);

    // 4: both pressed, BTN0 released at cycle 30
    do_reset();
    run_seq(4, 60);
    exp_q = '{7, 17, 27};
    check_list("t4_up", up_q, exp_q);
    exp_q = '{37, 47, 57};
    check_list("t4_dn", dn_q, exp_q);
    if (db0_hi.size() > 0) check("t4_db0_last", db0_hi[db0_hi.size()-1], 35);

    // 5: BTN0 held, reset pulse at cycles 12..13
    do_reset();
    run_seq(5, 45);
    exp_q = '{7, 21, 31, 41};
    check_list("t5_up", up_q, exp_q);
    check("t5_dn_count", dn_q.size(), 0);

    // 6: 3-cycle BTN0 glitch
    do_reset();
    run_seq(6, 20);
    check("t6_up_count", up_q.size(), 0);
    check("t6_db0_count", db0_hi.size(), 0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
